// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer/counter device: address, write strobe/data,
// combinational read word and the interrupt request back to the CPU.
interface timer_counter_if #(
  parameter int ADDR_WD = 4
);
  logic [ADDR_WD-1:0] Addr;
  logic               WE;
  logic [31:0]        DIN;
  logic [31:0]        DOUT;
  logic               IRQ;

  modport master (
    output Addr,
    output WE,
    output DIN,
    input  DOUT,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  DIN,
    output DOUT,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// Timer/counter device: CTRL/PRESET/COUNT registers, a four-state count FSM
// with one-shot and auto-reload modes, and a maskable level interrupt.
module timer_counter #(
  parameter int ADDR_WD = 4,
  parameter int CNT_WD  = 32
) (
  input logic           clk,
  input logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } stateT;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_PRESET = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;

  stateT             stateReg,   stateNext;
  logic [3:0]        ctrlReg,    ctrlNext;
  logic [CNT_WD-1:0] presetReg,  presetNext;
  logic [CNT_WD-1:0] countReg,   countNext;
  logic              pendingReg, pendingNext;
  logic              irqReg;

  logic [1:0] regSel;
  logic       ctrlWr;
  logic       presetWr;
  logic       enable;
  logic       autoReload;
  logic       pendingSet;
  logic       pendingClr;
  logic       unusedAddr;

  assign regSel     = bus.Addr[3:2];
  assign ctrlWr     = bus.WE && (regSel == SEL_CTRL);
  assign presetWr   = bus.WE && (regSel == SEL_PRESET);
  assign enable     = ctrlReg[0];
  // Only mode 1 reloads; modes 2 and 3 fall back to one-shot.
  assign autoReload = (ctrlReg[2:1] == 2'd1);
  assign unusedAddr = ^bus.Addr[1:0];

  always_comb begin
    stateNext   = stateReg;
    ctrlNext    = ctrlReg;
    presetNext  = presetReg;
    countNext   = countReg;
    pendingNext = pendingReg;
    pendingSet  = 1'b0;
    pendingClr  = 1'b0;

    case (stateReg)
      IDLE: begin
        if (enable) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        countNext = presetReg;
        stateNext = CNT;
      end
      CNT: begin
        if (!enable) begin
          stateNext = IDLE;
        end else if (countReg > CNT_WD'(1)) begin
          countNext = countReg - CNT_WD'(1);
        end else begin
          // Expiry on 1 or 0, so a zero preset behaves like one and COUNT never wraps.
          countNext  = '0;
          pendingSet = 1'b1;
          stateNext  = INT;
          if (!autoReload) begin
            ctrlNext[0] = 1'b0;
          end
        end
      end
      INT: begin
        if (autoReload && enable) begin
          pendingClr = 1'b1;
          stateNext  = LOAD;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // CPU write to CTRL overrides the one-shot enable clear on the same edge.
    if (ctrlWr) begin
      ctrlNext = bus.DIN[3:0];
    end
    if (presetWr) begin
      presetNext = CNT_WD'(bus.DIN);
    end

    // A set from the FSM beats any clear on the same edge.
    if (pendingSet) begin
      pendingNext = 1'b1;
    end else if (pendingClr || ctrlWr) begin
      pendingNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      ctrlReg    <= '0;
      presetReg  <= '0;
      countReg   <= '0;
      pendingReg <= 1'b0;
      irqReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      ctrlReg    <= ctrlNext;
      presetReg  <= presetNext;
      countReg   <= countNext;
      pendingReg <= pendingNext;
      irqReg     <= pendingNext & ctrlNext[3];
    end
  end

  assign bus.IRQ = irqReg;

  always_comb begin
    bus.DOUT = 32'd0;
    case (regSel)
      SEL_CTRL:   bus.DOUT = {28'd0, ctrlReg};
      SEL_PRESET: bus.DOUT = 32'(presetReg);
      SEL_COUNT:  bus.DOUT = 32'(countReg);
      default:    bus.DOUT = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, auto-reload,
// disable/re-enable, read-only space, masking and same-edge collisions.
module tb_timer_counter;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  timer_counter_if #(.ADDR_WD(4)) bus ();

  timer_counter #(.ADDR_WD(4), .CNT_WD(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Addr = a;
    bus.DIN  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    $display("WR addr=0x%h data=0x%h", a, d);
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOUT;
  endtask

  task automatic test_reset(input string tag);
    logic [31:0] v;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      busRead(4'(i * 4), v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL %s_read_%0d got=0x%h exp=0x0", tag, i * 4, v);
      end
    end
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL %s_irq got=%b exp=0", tag, bus.IRQ);
    end
    $display("RESET %s done", tag);
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] exp;
    busWrite(4'h4, 32'd3);
    busWrite(4'h0, 32'h9);
    tick();
    for (int e = 2; e <= 5; e++) begin
      tick();
      exp = 32'(5 - e);
      busRead(4'h8, v);
      checks++;
      if (v !== exp) begin
        failures++;
        $display("FAIL oneshot_count_e%0d got=%0d exp=%0d", e, v, exp);
      end
      checks++;
      if (bus.IRQ !== (e == 5)) begin
        failures++;
        $display("FAIL oneshot_irq_e%0d got=%b exp=%b", e, bus.IRQ, e == 5);
      end
    end
    busRead(4'h0, v);
    checks++;
    if (v !== 32'h8) begin
      failures++;
      $display("FAIL oneshot_ctrl_after got=0x%h exp=0x8", v);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.IRQ !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_irq_persist got=%b exp=1", bus.IRQ);
    end
    busWrite(4'h0, 32'h8);
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_irq_clear got=%b exp=0", bus.IRQ);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] expCount [12];
    logic        expIrq   [12];
    expCount = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
    expIrq   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    busWrite(4'h4, 32'd2);
    busWrite(4'h0, 32'hB);
    for (int e = 0; e < 12; e++) begin
      tick();
      busRead(4'h8, v);
      checks++;
      if (v !== expCount[e]) begin
        failures++;
        $display("FAIL reload_count_e%0d got=%0d exp=%0d", e + 1, v, expCount[e]);
      end
      checks++;
      if (bus.IRQ !== expIrq[e]) begin
        failures++;
        $display("FAIL reload_irq_e%0d got=%b exp=%b", e + 1, bus.IRQ, expIrq[e]);
      end
    end
    busRead(4'h0, v);
    checks++;
    if (v !== 32'hB) begin
      failures++;
      $display("FAIL reload_ctrl got=0x%h exp=0xb", v);
    end
    busWrite(4'h0, 32'h0);
    tick(); tick(); tick();
  endtask

  task automatic test_midcount_disable();
    logic [31:0] v;
    busWrite(4'h4, 32'd10);
    busWrite(4'h0, 32'h9);
    for (int e = 1; e <= 6; e++) tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd6) begin
      failures++;
      $display("FAIL disable_count_before got=%0d exp=6", v);
    end
    busWrite(4'h0, 32'h8);
    tick(); tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd5) begin
      failures++;
      $display("FAIL disable_count_frozen got=%0d exp=5", v);
    end
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL disable_irq got=%b exp=0", bus.IRQ);
    end
    busWrite(4'h0, 32'h9);
    tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd10) begin
      failures++;
      $display("FAIL disable_reload got=%0d exp=10", v);
    end
    busWrite(4'h0, 32'h8);
    tick(); tick();
  endtask

  task automatic test_readonly();
    logic [31:0] v;
    busWrite(4'h8, 32'hFFFF_FFFF);
    busWrite(4'hC, 32'hFFFF_FFFF);
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd9) begin
      failures++;
      $display("FAIL ro_count got=%0d exp=9", v);
    end
    busRead(4'hC, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL ro_reserved got=0x%h exp=0x0", v);
    end
    busRead(4'h4, v);
    checks++;
    if (v !== 32'd10) begin
      failures++;
      $display("FAIL ro_preset got=%0d exp=10", v);
    end
    busWrite(4'h0, 32'hFFFF_FFF0);
    busRead(4'h0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ro_ctrl_upper got=0x%h exp=0x0", v);
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    busWrite(4'h4, 32'd1);
    busWrite(4'h0, 32'h1);
    tick(); tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL mask_count got=%0d exp=0", v);
    end
    busRead(4'h0, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mask_ctrl got=0x%h exp=0x0", v);
    end
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL mask_irq_masked got=%b exp=0", bus.IRQ);
    end
    tick(); tick();
    busWrite(4'h0, 32'h8);
    tick();
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL mask_irq_after_unmask got=%b exp=0", bus.IRQ);
    end
  endtask

  task automatic test_preset_zero();
    logic [31:0] v;
    busWrite(4'h4, 32'd0);
    busWrite(4'h0, 32'h9);
    tick(); tick();
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL zero_irq_early got=%b exp=0", bus.IRQ);
    end
    tick();
    checks++;
    if (bus.IRQ !== 1'b1) begin
      failures++;
      $display("FAIL zero_irq_expiry got=%b exp=1", bus.IRQ);
    end
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL zero_count got=%0d exp=0", v);
    end
    busWrite(4'h0, 32'h8);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    busWrite(4'h4, 32'd2);
    busWrite(4'h0, 32'h9);
    tick(); tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd1) begin
      failures++;
      $display("FAIL b2b_count_pre got=%0d exp=1", v);
    end
    busWrite(4'h0, 32'h9);
    busRead(4'h0, v);
    checks++;
    if (v !== 32'h9) begin
      failures++;
      $display("FAIL b2b_ctrl_cpu_wins got=0x%h exp=0x9", v);
    end
    checks++;
    if (bus.IRQ !== 1'b1) begin
      failures++;
      $display("FAIL b2b_irq_set_wins got=%b exp=1", bus.IRQ);
    end
    busWrite(4'h0, 32'h8);
    checks++;
    if (bus.IRQ !== 1'b0) begin
      failures++;
      $display("FAIL b2b_irq_clear got=%b exp=0", bus.IRQ);
    end
    tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL b2b_count_idle got=%0d exp=0", v);
    end
  endtask

  task automatic test_preset_during_count();
    logic [31:0] v;
    busWrite(4'h4, 32'd5);
    busWrite(4'h0, 32'h9);
    tick(); tick();
    busWrite(4'h4, 32'd1);
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd4) begin
      failures++;
      $display("FAIL pcount_count got=%0d exp=4", v);
    end
    busRead(4'h4, v);
    checks++;
    if (v !== 32'd1) begin
      failures++;
      $display("FAIL pcount_preset got=%0d exp=1", v);
    end
    tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd3) begin
      failures++;
      $display("FAIL pcount_count_next got=%0d exp=3", v);
    end
    busWrite(4'h0, 32'h8);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    busWrite(4'h4, 32'd5);
    busWrite(4'h0, 32'h9);
    tick(); tick(); tick();
    test_reset("reset_mid");
    tick(); tick(); tick();
    busRead(4'h8, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_count_hold got=%0d exp=0", v);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.DIN  = '0;
    test_reset("reset");
    test_oneshot();
    test_autoreload();
    test_midcount_disable();
    test_readonly();
    test_mask();
    test_preset_zero();
    test_back_to_back();
    test_preset_during_count();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Timer/counter device (DEV_TC) directly downstream of the CPU–device bridge.
- Consumes the bridge's device address, write data and write strobe; its read data returns to the bridge as the TC read word.
- Raises an interrupt request when the count expires.
- Supports one-shot mode and auto-reload mode.

Parameters:
- ADDR_WD, 4, width of the device-local byte address from the bridge (must equal DEV_ADDR_WD).
- CNT_WD, 32, width of the PRESET and COUNT registers.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  ADDR_WD  device-local byte address from the bridge; Addr[3:2] selects the register, Addr[1:0] is ignored.
- WE  input  1  write enable from the bridge; sampled on the rising edge.
- DIN  input  32  write data from the bridge.
- DOUT  output  32  read data to the bridge (DEV_TC read word); combinational.
- IRQ  output  1  interrupt request to the CPU; level, registered.

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 = CTRL, read/write. Bit 0 Enable; bits 2:1 Mode; bit 3 IM (interrupt mask). Bits 31:4 read 0.
  - 1 = PRESET, read/write, CNT_WD bits.
  - 2 = COUNT, read-only; writes are ignored.
  - 3 = reserved; reads 0, writes ignored.
- Mode 0 is one-shot. Mode 1 is auto-reload. Modes 2 and 3 behave as mode 0.
- DOUT is a pure combinational mux of the currently registered values; a write becomes visible the cycle after the edge.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state=IDLE. IRQ=0 and DOUT reflects zeros.
- IRQ = irq_pending & CTRL.IM.
- FSM states are IDLE, LOAD, CNT, INT. Transition decisions use the register values held before the current edge.
  - IDLE: Enable=1 -> LOAD. Otherwise stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - Enable=0 -> IDLE; COUNT holds.
    - Else if COUNT>1: COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0): COUNT<=0, irq_pending<=1 -> INT. In mode 0, Enable is also cleared on this edge.
  - INT:
    - Mode 1 with Enable=1: irq_pending<=0 -> LOAD.
    - Otherwise -> IDLE; irq_pending holds.
- Latency: from the Enable write edge, COUNT is loaded 2 edges later. With PRESET=N≥1, irq_pending sets N+2 edges after the Enable write. Mode 1 period is N+2 cycles, with irq_pending high for exactly 1 cycle per period.
- Any CTRL write clears irq_pending. Mode-0 irq_pending otherwise persists.
- Simultaneous events:
  - A CPU write to CTRL on the same edge that mode 0 clears Enable: the CPU write wins.
  - A CTRL write clearing irq_pending on the same edge the FSM sets it: the set wins.
- A PRESET write while counting does not disturb COUNT; it takes effect at the next LOAD.
- Clearing Enable mid-count: FSM enters IDLE the next edge and COUNT freezes. Re-enabling goes through LOAD, so COUNT restarts from PRESET.
- PRESET=0 behaves like PRESET=1: expiry occurs on the first CNT cycle.
- COUNT never wraps below 0.
- Reset asserted mid-operation overrides everything on that edge.

Test Plan:
- Reset, then read Addr=0x0, 0x4, 0x8, 0xC -> DOUT=0 for each; IRQ=0.
- Write PRESET=3, then CTRL=0x9 (Enable, mode 0, IM) at edge e0 -> COUNT=3 after e2, 2 after e3, 1 after e4, 0 after e5. IRQ=1 after e5; CTRL reads 0x8. IRQ stays 1 until a CTRL write of 0x8, after which IRQ=0.
- Mode 1: PRESET=2, CTRL=0xB -> IRQ pulses high for exactly 1 cycle every 4 cycles. COUNT sequence is 2,1,0 then reloads 2; Enable stays 1.
- Mid-count disable: PRESET=10, enable, then write CTRL=0x8 when COUNT=6 -> COUNT freezes at 6 (or 5 if an edge decremented it first), no IRQ. Re-enable -> COUNT reloads 10.
- Write 0xFFFF_FFFF to COUNT (Addr=0x8) and to Addr=0xC -> COUNT unchanged and 0xC reads 0. Write CTRL=0xFFFF_FFF0 -> CTRL reads 0x0.
- IM=0 with expiry -> IRQ stays 0 while the internal pending flag is set. A later write of CTRL=0x8 clears the flag, so IRQ stays 0.
